// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
package piso_pkg;

   // Two-state controller: line idle, or a word is being shifted out.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Serial line level when no data bit is on it.
   localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/piso_hold.sv
// One-entry holding buffer: parks the next word while the current one shifts.
module piso_hold
   import piso_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_write,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ord,
   input  logic             i_take,
   output logic             o_full,
   output logic [WIDTH-1:0] o_data,
   output logic             o_ord
);

   logic             r_full;
   logic [WIDTH-1:0] r_data;
   logic             r_ord;

   // Write fills the slot, take empties it. The parent only writes when the
   // slot is empty and only takes when it is full, so the two never coincide;
   // write is given priority regardless.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_full <= 1'b0;
         r_data <= '0;
         r_ord  <= 1'b0;
      end else if (i_write) begin
         r_full <= 1'b1;
         r_data <= i_data;
         r_ord  <= i_ord;
      end else if (i_take) begin
         r_full <= 1'b0;
      end
   end

   assign o_full = r_full;
   assign o_data = r_data;
   assign o_ord  = r_ord;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: valid/ready word input, one bit per clock out,
// MSB- or LSB-first per word, with a one-word holding buffer for gapless streams.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data,
   input  logic             msb_first,
   input  logic             valid,
   output logic             ready,
   output logic             s,
   output logic             s_valid,
   output logic             last
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_sh, w_sh_nxt;
   logic             r_ord, w_ord_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

   logic             w_acc;
   logic             w_last;
   logic             w_hold_wr;
   logic             w_hold_take;
   logic             w_hold_full;
   logic [WIDTH-1:0] w_hold_data;
   logic             w_hold_ord;

   // Ready drops while reset is held, and whenever the holding slot is occupied.
   assign ready  = reset && !w_hold_full;
   assign w_acc  = valid && ready;
   assign w_last = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);

   piso_hold #(.WIDTH(WIDTH)) u_hold (
      .clk     (clk),
      .reset   (reset),
      .i_write (w_hold_wr),
      .i_data  (data),
      .i_ord   (msb_first),
      .i_take  (w_hold_take),
      .o_full  (w_hold_full),
      .o_data  (w_hold_data),
      .o_ord   (w_hold_ord)
   );

   // State, shifter, order flag and bit counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_sh    <= '0;
         r_ord   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sh    <= w_sh_nxt;
         r_ord   <= w_ord_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state and datapath update. At the word's final bit the held word
   // takes precedence; otherwise a coinciding accept bypasses the buffer so
   // back-to-back words never leave a gap.
   always_comb begin
      w_state_nxt = r_state;
      w_sh_nxt    = r_sh;
      w_ord_nxt   = r_ord;
      w_cnt_nxt   = r_cnt;
      w_hold_wr   = 1'b0;
      w_hold_take = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_acc) begin
               w_sh_nxt    = data;
               w_ord_nxt   = msb_first;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!w_last) begin
               w_sh_nxt  = r_ord ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};
               w_cnt_nxt = r_cnt + CNT_W'(1);
               w_hold_wr = w_acc;
            end else if (w_hold_full) begin
               w_sh_nxt    = w_hold_data;
               w_ord_nxt   = w_hold_ord;
               w_cnt_nxt   = '0;
               w_hold_take = 1'b1;
            end else if (w_acc) begin
               w_sh_nxt  = data;
               w_ord_nxt = msb_first;
               w_cnt_nxt = '0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Serial outputs decoded from registered state only.
   always_comb begin
      s       = IDLE_LEVEL;
      s_valid = 1'b0;
      last    = 1'b0;
      if (r_state == ST_SHIFT) begin
         s       = r_ord ? r_sh[WIDTH-1] : r_sh[0];
         s_valid = 1'b1;
         last    = w_last;
      end
   end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that sits directly upstream of the serial 1101 pattern detector and drives its one-bit `x` input. Words are accepted through a valid/ready handshake and shifted out one bit per clock, MSB- or LSB-first. A one-entry holding buffer lets consecutive words stream with no idle gap. When no word is in flight, the serial line rests at a fixed idle level.

## Interface
- `WIDTH`, default 8: word width in bits; legal range ≥ 2.
- `IDLE_LEVEL`, default 1'b0: level driven on `s` when no bit is valid.

- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset, named as elsewhere in the codebase. Asserting it forces reset state immediately; deassertion takes effect synchronously to `clk`.
- `data`, in, WIDTH: parallel word.
- `msb_first`, in, 1: bit order for the word; sampled together with `data`.
- `valid`, in, 1: the producer offers `data`/`msb_first`.
- `ready`, out, 1: the block can accept a word. Transfer occurs when `valid && ready` is high at a rising edge.
- `s`, out, 1: serial bit; connects to the detector's `x`.
- `s_valid`, out, 1: `s` carries a data bit this cycle.
- `last`, out, 1: `s` carries the final bit of a word.

## Operation
- State machine with two states: IDLE and SHIFT.
- Internal storage: shift register `sh[WIDTH-1:0]`, order flag `ord`, bit counter `cnt` of width `$clog2(WIDTH)`, holding register `hold` plus `hold_ord`, and flag `hold_full`.
- `ready = reset && !hold_full`. `ready` is 0 while reset is asserted.
- IDLE, on an accept: load the word into `sh`/`ord`, set `cnt=0`, go to SHIFT. The holding buffer is bypassed.
- SHIFT drives the following outputs:
  - `s = ord ? sh[WIDTH-1] : sh[0]`
  - `s_valid = 1`
  - `last = (cnt == WIDTH-1)`
- SHIFT, on each edge with `last = 0`:
  - Shift `sh` toward the output end (left if `ord`, else right).
  - Increment `cnt`.
  - An accept in the same cycle writes `hold` and sets `hold_full`.
- SHIFT, on an edge with `last = 1`:
  - If `hold_full`: move `hold` into `sh`, clear `hold_full`, set `cnt=0`, stay in SHIFT.
  - Else, if an accept occurs this cycle: load the incoming word directly into `sh` (bypass), set `cnt=0`, stay in SHIFT.
  - Else: go to IDLE.
- IDLE outputs: `s = IDLE_LEVEL`, `s_valid = 0`, `last = 0`.
- `valid` with `ready = 0` is ignored. The producer holds `data` until it is accepted.
- Reset values: state IDLE, `s = IDLE_LEVEL`, `s_valid = 0`, `last = 0`, `hold_full = 0`, `cnt = 0`, `sh = 0`. After reset deasserts, `ready = 1`.

## Timing
- Latency: a word accepted at edge k puts its first bit on `s` in the cycle after edge k. Its bits occupy WIDTH consecutive cycles, and `last` is high in the final one.
- Throughput: one word per WIDTH cycles when `valid` is continuously high. There is no bubble between words.
- Backpressure: with one word shifting and one held, `ready` is 0.
  - `ready` returns to 1 in the cycle after the edge where the held word moves into `sh`.
- Simultaneous events:
  - An accept coinciding with `last` while the buffer is empty uses the bypass; `hold` stays empty.
  - An accept coinciding with `last` while `hold_full` cannot occur, because `ready` is 0.
- Reset mid-word:
  - Outputs go to their reset values immediately (asynchronously).
  - In-flight and held words are discarded; no partial word resumes.
- `s`, `s_valid` and `last` are decoded only from registered state. They carry no combinational path from inputs.

## Structure
- Shared package `piso_pkg`:
  - State encoding constants ST_IDLE = 1'b0, ST_SHIFT = 1'b1.
  - Default idle level constant.
- One sub-module is natural: `piso_hold`, the one-entry holding buffer.
  - Inputs: write, data, order, take.
  - Outputs: full, data, order.
  - Same `clk`/`reset` as the parent.
- The rest of the logic (FSM, counter, shifter) lives in `piso_serializer`.

## Test plan
All scenarios use WIDTH = 4 and IDLE_LEVEL = 0.

- **Single word:** accept `data = 4'b1101`, `msb_first = 1` at edge 0.
  - `s` = 1, 1, 0, 1 over cycles 1–4, with `s_valid = 1` throughout; `last` is high only in cycle 4.
  - From cycle 5: `s = 0`, `s_valid = 0`.
  - The downstream detector `y` rises one edge after the final 1 is sampled.
- **LSB-first:** accept `4'b1011`, `msb_first = 0`.
  - `s` = 1, 1, 0, 1 over cycles 1–4.
- **Back-to-back:** hold `valid` high with `4'b1101` then `4'b0110`.
  - `s` = 1,1,0,1,0,1,1,0 over 8 contiguous cycles, with no gap.
  - `last` is high in cycles 4 and 8.
- **Backpressure:** present 3 words with `valid` held high.
  - `ready` goes low after the second accept and rises again after cycle 4's edge.
  - All 12 bits are emitted in order with none dropped or duplicated.
- **Reset mid-word:** pull `reset` low after 2 bits of `4'b1101`.
  - `s`, `s_valid` and `last` go to 0 immediately.
  - After release, `ready = 1` and the line stays idle until a new accept.
- **Idle hold:** 10 cycles with `valid = 0` after reset.
  - `s = 0`, `s_valid = 0` and `ready = 1` throughout.
